// File: rtl/team_turn_controller_if.sv
// Key, game-status and score inputs plus team/score/winner outputs.
// slave: controller side; master: the surrounding game logic.
`timescale 1ns/1ps
interface team_turn_controller_if #(
    parameter int SCORE_W = 8
);
    logic                 left_key_press;
    logic                 right_key_press;
    logic                 up_key_press;
    logic                 down_key_press;
    logic [1:0]           game_status;
    logic [SCORE_W-1:0]   score;
    logic [1:0]           current_team;
    logic [SCORE_W+3:0]   team1_total;
    logic [SCORE_W+3:0]   team2_total;
    logic [3:0]           round_num;
    logic                 score_reset;
    logic                 game_complete;
    logic [1:0]           winner;

    modport master (
        output left_key_press,
        output right_key_press,
        output up_key_press,
        output down_key_press,
        output game_status,
        output score,
        input  current_team,
        input  team1_total,
        input  team2_total,
        input  round_num,
        input  score_reset,
        input  game_complete,
        input  winner
    );

    modport slave (
        input  left_key_press,
        input  right_key_press,
        input  up_key_press,
        input  down_key_press,
        input  game_status,
        input  score,
        output current_team,
        output team1_total,
        output team2_total,
        output round_num,
        output score_reset,
        output game_complete,
        output winner
    );
endinterface

// File: rtl/team_turn_controller.sv
// Two-team snake match sequencer: team pick, alternating turns, totals, winner.
// Ports: clk, rst (sync, active-high), bus (team_turn_controller_if.slave).
// Optional: define SUDDEN_DEATH_EN to extend tied matches one round at a time.
`timescale 1ns/1ps
module team_turn_controller #(
    parameter int SCORE_W       = 8,
    parameter int NUM_ROUNDS    = 3,
    parameter int SWITCH_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    team_turn_controller_if.slave  bus
);

    localparam int TOT_W = SCORE_W + 4;
    localparam int CNT_W = (SWITCH_CYCLES > 1) ? $clog2(SWITCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SWITCH_CYCLES - 1);
    localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS);

    localparam logic [1:0] ST_RESTART = 2'b00;
    localparam logic [1:0] ST_START   = 2'b01;
    localparam logic [1:0] ST_PLAY    = 2'b10;
    localparam logic [1:0] ST_DIE     = 2'b11;

    typedef enum logic [2:0] {
        SELECT,
        WAIT_PLAY,
        PLAYING,
        HANDOVER,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         team_q, team_d;
    logic [1:0]         first_q, first_d;
    logic [1:0]         played_q, played_d;
    logic [3:0]         round_q, round_d;
    logic [TOT_W-1:0]   t1_q, t1_d;
    logic [TOT_W-1:0]   t2_q, t2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sr_q, sr_d;
    logic               done_q, done_d;
    logic [1:0]         winner_q, winner_d;

    logic lr_key;
    logic ud_key;
    logic is_play;
    logic is_die;
    logic is_idle;
    logic match_over;

    assign lr_key  = bus.left_key_press | bus.right_key_press;
    assign ud_key  = bus.up_key_press | bus.down_key_press;
    assign is_play = (bus.game_status == ST_PLAY);
    assign is_die  = (bus.game_status == ST_DIE);
    assign is_idle = (bus.game_status == ST_RESTART) ||
                     (bus.game_status == ST_START);

    // Decided at a round boundary, after both turns have accumulated.
`ifdef SUDDEN_DEATH_EN
    assign match_over = (round_q >= LAST_ROUND) &&
                        ((t1_q != t2_q) || (round_q == 4'd15));
`else
    assign match_over = (round_q >= LAST_ROUND);
`endif

    function automatic logic [TOT_W-1:0] sat_add(
        input logic [TOT_W-1:0]   acc,
        input logic [SCORE_W-1:0] s
    );
        logic [TOT_W:0] sum;
        sum = {1'b0, acc} + (TOT_W+1)'(s);
        return sum[TOT_W] ? {TOT_W{1'b1}} : sum[TOT_W-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        team_d   = team_q;
        first_d  = first_q;
        played_d = played_q;
        round_d  = round_q;
        t1_d     = t1_q;
        t2_d     = t2_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;

        unique case (state_q)
            SELECT: begin
                // Left/right outranks up/down on a simultaneous press.
                if (lr_key) begin
                    team_d = 2'd1;
                end else if (ud_key) begin
                    team_d = 2'd2;
                end
                if (is_play) begin
                    first_d = team_d;
                    state_d = PLAYING;
                end
            end
            WAIT_PLAY: begin
                if (is_play) begin
                    state_d = PLAYING;
                end
            end
            PLAYING: begin
                unique case (1'b1)
                    is_die: begin
                        if (team_q == 2'd2) begin
                            t2_d        = sat_add(t2_q, bus.score);
                            played_d[1] = 1'b1;
                        end else begin
                            t1_d        = sat_add(t1_q, bus.score);
                            played_d[0] = 1'b1;
                        end
                        cnt_d   = '0;
                        state_d = HANDOVER;
                    end
                    is_idle: begin
                        state_d = WAIT_PLAY;
                    end
                    default: begin
                    end
                endcase
            end
            HANDOVER: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = WAIT_PLAY;
                    if (&played_q) begin
                        // Every round opens with the starting team.
                        team_d   = first_q;
                        played_d = 2'b00;
                        if (match_over) begin
                            state_d = DONE;
                        end else begin
                            round_d = round_q + 4'd1;
                        end
                    end else begin
                        team_d = (team_q == 2'd1) ? 2'd2 : 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
            end
            default: begin
                state_d = SELECT;
            end
        endcase

        if ((state_d == DONE) && (state_q != DONE)) begin
            if (t1_q > t2_q) begin
                winner_d = 2'd1;
            end else if (t2_q > t1_q) begin
                winner_d = 2'd2;
            end else begin
                winner_d = 2'd3;
            end
        end

        // Registered so the pulse lands on the last dwell cycle.
        sr_d   = (state_d == HANDOVER) && (cnt_d == CNT_LAST);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SELECT;
            team_q   <= 2'd1;
            first_q  <= 2'd1;
            played_q <= 2'b00;
            round_q  <= 4'd1;
            t1_q     <= '0;
            t2_q     <= '0;
            cnt_q    <= '0;
            sr_q     <= 1'b0;
            done_q   <= 1'b0;
            winner_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            team_q   <= team_d;
            first_q  <= first_d;
            played_q <= played_d;
            round_q  <= round_d;
            t1_q     <= t1_d;
            t2_q     <= t2_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            done_q   <= done_d;
            winner_q <= winner_d;
        end
    end

    assign bus.current_team  = team_q;
    assign bus.team1_total   = t1_q;
    assign bus.team2_total   = t2_q;
    assign bus.round_num     = round_q;
    assign bus.score_reset   = sr_q;
    assign bus.game_complete = done_q;
    assign bus.winner        = winner_q;

endmodule

// File: tb/tb_team_turn_controller.sv
// Bench for team_turn_controller: two instances, score_reset scoreboards.
// Instance a: 1 round, 4-cycle dwell. Instance b: long/tied match, 2-cycle dwell.
`timescale 1ns/1ps
module tb_team_turn_controller;

    localparam int SW = 8;
`ifdef SUDDEN_DEATH_EN
    localparam int B_ROUNDS = 2;
`else
    localparam int B_ROUNDS = 15;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    team_turn_controller_if #(.SCORE_W(SW)) bus_a ();
    team_turn_controller_if #(.SCORE_W(SW)) bus_b ();

    team_turn_controller #(
        .SCORE_W(SW), .NUM_ROUNDS(1), .SWITCH_CYCLES(4)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave)
    );

    team_turn_controller #(
        .SCORE_W(SW), .NUM_ROUNDS(B_ROUNDS), .SWITCH_CYCLES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave)
    );

    typedef struct {
        int t1;
        int t2;
        int team;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int n_checks = 0;
    int n_err    = 0;
    int sr_cnt_a = 0;
    int sr_cnt_b = 0;
    int mb_t1    = 0;
    int mb_t2    = 0;
    int mb_team  = 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(inout exp_t q[$], input int t1, input int t2,
                            input int team);
        exp_t e;
        e.t1   = t1;
        e.t2   = t2;
        e.team = team;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.score_reset === 1'b1) begin
            sr_cnt_a++;
            if (q_a.size() == 0) begin
                check("a_sr_unexpected", 1, 0);
            end else begin
                e = q_a.pop_front();
                check("a_sr_t1", 32'(bus_a.team1_total), e.t1);
                check("a_sr_t2", 32'(bus_a.team2_total), e.t2);
                check("a_sr_team", 32'(bus_a.current_team), e.team);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus_b.score_reset === 1'b1) begin
            sr_cnt_b++;
            if (q_b.size() == 0) begin
                check("b_sr_unexpected", 1, 0);
            end else begin
                e = q_b.pop_front();
                check("b_sr_t1", 32'(bus_b.team1_total), e.t1);
                check("b_sr_t2", 32'(bus_b.team2_total), e.t2);
                check("b_sr_team", 32'(bus_b.current_team), e.team);
            end
        end
    end

    task automatic idle_a;
        bus_a.left_key_press  = 1'b0;
        bus_a.right_key_press = 1'b0;
        bus_a.up_key_press    = 1'b0;
        bus_a.down_key_press  = 1'b0;
        bus_a.game_status     = 2'b00;
        bus_a.score           = '0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_team"}, 32'(bus_a.current_team), 1);
        check({tag, "_t1"}, 32'(bus_a.team1_total), 0);
        check({tag, "_t2"}, 32'(bus_a.team2_total), 0);
        check({tag, "_round"}, 32'(bus_a.round_num), 1);
        check({tag, "_sr"}, 32'(bus_a.score_reset), 0);
        check({tag, "_done"}, 32'(bus_a.game_complete), 0);
        check({tag, "_winner"}, 32'(bus_a.winner), 0);
    endtask

    // One full turn on b: die with score s, dwell, then resume play.
    task automatic b_turn(input int s);
        bus_b.score       = SW'(s);
        bus_b.game_status = 2'b11;
        if (mb_team == 1) begin
            mb_t1 = (mb_t1 + s > 4095) ? 4095 : mb_t1 + s;
        end else begin
            mb_t2 = (mb_t2 + s > 4095) ? 4095 : mb_t2 + s;
        end
        push_exp(q_b, mb_t1, mb_t2, mb_team);
        mb_team = 3 - mb_team;
        tick;
        bus_b.game_status = 2'b01;
        tick;
        tick;
        bus_b.game_status = 2'b10;
        tick;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sr_at;
        int sr_seen;
        int t1_at1;
        int team5;

        idle_a();
        bus_b.left_key_press  = 1'b0;
        bus_b.right_key_press = 1'b0;
        bus_b.up_key_press    = 1'b0;
        bus_b.down_key_press  = 1'b0;
        bus_b.game_status     = 2'b00;
        bus_b.score           = '0;

        rst = 1'b1;
        repeat (2) tick;
        check_reset_a("rst");
        rst = 1'b0;

        bus_a.up_key_press = 1'b1;
        tick;
        bus_a.up_key_press = 1'b0;
        check("sel_up", 32'(bus_a.current_team), 2);
        bus_a.up_key_press   = 1'b1;
        bus_a.left_key_press = 1'b1;
        tick;
        idle_a();
        check("sel_both", 32'(bus_a.current_team), 1);
        bus_a.down_key_press = 1'b1;
        tick;
        idle_a();
        check("sel_down", 32'(bus_a.current_team), 2);
        bus_a.left_key_press = 1'b1;
        bus_a.game_status    = 2'b10;
        tick;
        bus_a.left_key_press = 1'b0;
        check("play_team", 32'(bus_a.current_team), 1);
        check("play_round", 32'(bus_a.round_num), 1);

        bus_a.game_status = 2'b00;
        tick;
        check("abort_team", 32'(bus_a.current_team), 1);
        check("abort_t1", 32'(bus_a.team1_total), 0);
        bus_a.up_key_press = 1'b1;
        tick;
        bus_a.up_key_press = 1'b0;
        check("wait_key_ignored", 32'(bus_a.current_team), 1);
        check("abort_no_sr", 32'(sr_cnt_a), 0);
        bus_a.game_status = 2'b10;
        tick;

        sr_at   = 0;
        sr_seen = 0;
        t1_at1  = -1;
        team5   = -1;
        bus_a.score       = 8'd7;
        bus_a.game_status = 2'b11;
        push_exp(q_a, 7, 0, 1);
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (bus_a.score_reset === 1'b1) begin
                sr_at = i;
                sr_seen++;
            end
            if (i == 1) t1_at1 = 32'(bus_a.team1_total);
            if (i == 5) team5 = 32'(bus_a.current_team);
        end
        check("ho_t1_next", t1_at1, 7);
        check("ho_sr_cycle", sr_at, 4);
        check("ho_sr_width", sr_seen, 1);
        check("ho_team_after", team5, 2);
        check("ho_t1_once", 32'(bus_a.team1_total), 7);
        check("ho_team_hold", 32'(bus_a.current_team), 2);
        check("ho_round", 32'(bus_a.round_num), 1);

        bus_a.game_status = 2'b10;
        tick;
        bus_a.score       = 8'd9;
        bus_a.game_status = 2'b11;
        push_exp(q_a, 7, 9, 2);
        for (int k = 0; k < 20 && bus_a.game_complete !== 1'b1; k++) tick;
        check("end_complete", 32'(bus_a.game_complete), 1);
        check("end_winner", 32'(bus_a.winner), 2);
        check("end_t2", 32'(bus_a.team2_total), 9);
        check("end_t1", 32'(bus_a.team1_total), 7);
        check("end_sr_count", 32'(sr_cnt_a), 2);
        bus_a.game_status    = 2'b10;
        bus_a.up_key_press   = 1'b1;
        repeat (4) tick;
        idle_a();
        check("done_hold", 32'(bus_a.game_complete), 1);
        check("done_team", 32'(bus_a.current_team), 1);
        check("done_winner", 32'(bus_a.winner), 2);

        bus_b.game_status = 2'b10;
        tick;
        check("b_play_team", 32'(bus_b.current_team), 1);
`ifdef SUDDEN_DEATH_EN
        b_turn(255);
        b_turn(255);
        b_turn(255);
        b_turn(255);
        check("sd_round3", 32'(bus_b.round_num), 3);
        check("sd_not_done", 32'(bus_b.game_complete), 0);
        b_turn(100);
        b_turn(50);
        check("sd_complete", 32'(bus_b.game_complete), 1);
        check("sd_winner", 32'(bus_b.winner), 1);
        check("sd_t1", 32'(bus_b.team1_total), 610);
        check("sd_t2", 32'(bus_b.team2_total), 560);
        check("sd_round", 32'(bus_b.round_num), 3);
        check("sd_sr_count", 32'(sr_cnt_b), 6);
`else
        for (int r = 1; r <= 15; r++) begin
            b_turn(255);
            b_turn(255);
            if (r == 1) check("tie_round2", 32'(bus_b.round_num), 2);
        end
        check("tie_t1", 32'(bus_b.team1_total), 3825);
        check("tie_t2", 32'(bus_b.team2_total), 3825);
        check("tie_complete", 32'(bus_b.game_complete), 1);
        check("tie_winner", 32'(bus_b.winner), 3);
        check("tie_round", 32'(bus_b.round_num), 15);
        check("tie_sr_count", 32'(sr_cnt_b), 30);
`endif

        rst = 1'b1;
        tick;
        rst = 1'b0;
        idle_a();
        bus_a.game_status = 2'b10;
        tick;
        bus_a.score       = 8'd5;
        bus_a.game_status = 2'b11;
        tick;
        check("mid_t1", 32'(bus_a.team1_total), 5);
        tick;
        rst = 1'b1;
        tick;
        check_reset_a("mid_rst");
        rst = 1'b0;
        bus_a.game_status = 2'b00;
        repeat (8) tick;
        check("mid_no_sr", 32'(sr_cnt_a), 2);
        check("mid_t1_after", 32'(bus_a.team1_total), 0);

        check("a_pending", 32'(q_a.size()), 0);
        check("b_pending", 32'(q_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
